// File: rtl/view_vertex_transformer_pkg.sv
// view_vertex_transformer_pkg: shared fixed-point types, constants and FSM encodings for the view pipeline
// Used by view_vertex_transformer and the view-matrix calculator; no ports.
package view_vertex_transformer_pkg;
    localparam int COORD_W  = 32;
    localparam int FIX_FRAC = 16;
    localparam int TAG_W    = 8;
    typedef logic signed [COORD_W-1:0] coord_t;
    typedef coord_t [3:0] vec4_t;
    typedef vec4_t [3:0] mat4_t;
    localparam coord_t FIX_ONE  = coord_t'(1) <<< FIX_FRAC;
    localparam coord_t FIX_ZERO = '0;
    // Row 3 is the most significant slice, so rows are listed 3..0 and columns 3..0.
    localparam mat4_t MAT_IDENTITY = {
        {FIX_ONE,  FIX_ZERO, FIX_ZERO, FIX_ZERO},
        {FIX_ZERO, FIX_ONE,  FIX_ZERO, FIX_ZERO},
        {FIX_ZERO, FIX_ZERO, FIX_ONE,  FIX_ZERO},
        {FIX_ZERO, FIX_ZERO, FIX_ZERO, FIX_ONE}
    };
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ROW  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;
    // Clamp a wide accumulator result into the coordinate range.
    function automatic coord_t sat_coord(input logic signed [2*COORD_W+1:0] v);
        return (v > (2*COORD_W+2)'($signed({1'b0, {(COORD_W-1){1'b1}}}))) ? {1'b0, {(COORD_W-1){1'b1}}} :
               (v < (2*COORD_W+2)'($signed({1'b1, {(COORD_W-1){1'b0}}}))) ? {1'b1, {(COORD_W-1){1'b0}}} :
               v[COORD_W-1:0];
    endfunction
endpackage

// File: rtl/view_vertex_transformer_dot.sv
// fixed_dot4_sat: one matrix row dotted with [x y z 1], shifted back to fixed point and saturated
// Ports: i_row (row elements [col]), i_x/i_y/i_z (vertex), o_res (saturated row result); purely combinational.
module fixed_dot4_sat #(
    parameter int COORD_WIDTH = 32,
    parameter int FRAC_BITS   = 16
) (
    input  logic [3:0][COORD_WIDTH-1:0] i_row,
    input  logic signed [COORD_WIDTH-1:0] i_x,
    input  logic signed [COORD_WIDTH-1:0] i_y,
    input  logic signed [COORD_WIDTH-1:0] i_z,
    output logic signed [COORD_WIDTH-1:0] o_res
);
    localparam int AW = 2*COORD_WIDTH+2;
    localparam logic signed [AW-1:0] MAXV = AW'($signed({1'b0, {(COORD_WIDTH-1){1'b1}}}));
    localparam logic signed [AW-1:0] MINV = AW'($signed({1'b1, {(COORD_WIDTH-1){1'b0}}}));
    function automatic logic signed [AW-1:0] sx(input logic [COORD_WIDTH-1:0] v);
        return AW'($signed(v));
    endfunction
    logic signed [AW-1:0] w_acc;
    logic signed [AW-1:0] w_sh;
    // Implicit w = 1.0 means the translation column enters pre-scaled by 2^FRAC_BITS.
    assign w_acc = sx(i_row[0])*sx(i_x) + sx(i_row[1])*sx(i_y) + sx(i_row[2])*sx(i_z) + (sx(i_row[3]) <<< FRAC_BITS);
    assign w_sh  = w_acc >>> FRAC_BITS;
    assign o_res = (w_sh > MAXV) ? {1'b0, {(COORD_WIDTH-1){1'b1}}} :
                   (w_sh < MINV) ? {1'b1, {(COORD_WIDTH-1){1'b0}}} : w_sh[COORD_WIDTH-1:0];
endmodule

// File: rtl/view_vertex_transformer.sv
// view_vertex_transformer: applies the active 4x4 view matrix to one vertex at a time, one row per cycle
// Ports: clk_in, rst_in (async active-low); matrix_valid/view_matrix load a matrix;
// in_valid/in_ready with x_in/y_in/z_in/tag_in accept a vertex; out_valid/out_ready with x/y/z/w_out, tag_out return it.
module view_vertex_transformer
    import view_vertex_transformer_pkg::*;
#(
    parameter int COORD_WIDTH = COORD_W,
    parameter int FRAC_BITS   = FIX_FRAC,
    parameter int TAG_WIDTH   = TAG_W
) (
    input  logic                                clk_in,
    input  logic                                rst_in,
    input  logic                                matrix_valid,
    input  logic [3:0][3:0][COORD_WIDTH-1:0]    view_matrix,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic signed [COORD_WIDTH-1:0]       x_in,
    input  logic signed [COORD_WIDTH-1:0]       y_in,
    input  logic signed [COORD_WIDTH-1:0]       z_in,
    input  logic [TAG_WIDTH-1:0]                tag_in,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic signed [COORD_WIDTH-1:0]       x_out,
    output logic signed [COORD_WIDTH-1:0]       y_out,
    output logic signed [COORD_WIDTH-1:0]       z_out,
    output logic signed [COORD_WIDTH-1:0]       w_out,
    output logic [TAG_WIDTH-1:0]                tag_out
);
    localparam logic [COORD_WIDTH-1:0] ONE = COORD_WIDTH'(1) << FRAC_BITS;
    logic [1:0]                         r_state;
    logic [1:0]                         r_row;
    logic                               r_live;
    logic                               r_pend;
    logic [3:0][3:0][COORD_WIDTH-1:0]   r_mat;
    logic [3:0][3:0][COORD_WIDTH-1:0]   r_pend_mat;
    logic signed [COORD_WIDTH-1:0]      r_x;
    logic signed [COORD_WIDTH-1:0]      r_y;
    logic signed [COORD_WIDTH-1:0]      r_z;
    logic [TAG_WIDTH-1:0]               r_tag;
    logic [3:0][COORD_WIDTH-1:0]        r_res;
    logic signed [COORD_WIDTH-1:0]      w_dot;
    // r_live holds in_ready low until the first clock after reset release; a pending
    // matrix also blocks acceptance for the IDLE cycle in which it is applied.
    assign in_ready  = r_live && (r_state == S_IDLE) && !matrix_valid && !r_pend;
    assign out_valid = r_state == S_OUT;
    assign x_out     = r_res[0];
    assign y_out     = r_res[1];
    assign z_out     = r_res[2];
    assign w_out     = r_res[3];
    assign tag_out   = r_tag;
    fixed_dot4_sat #(.COORD_WIDTH(COORD_WIDTH), .FRAC_BITS(FRAC_BITS)) u_dot (
        .i_row (r_mat[r_row]),
        .i_x   (r_x),
        .i_y   (r_y),
        .i_z   (r_z),
        .o_res (w_dot)
    );
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state    <= S_IDLE;
            r_row      <= '0;
            r_live     <= 1'b0;
            r_pend     <= 1'b0;
            r_pend_mat <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_z        <= '0;
            r_tag      <= '0;
            r_res      <= '0;
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    r_mat[i][j] <= (i == j) ? ONE : '0;
        end else begin
            r_live <= 1'b1;
            if (r_state == S_IDLE) begin
                if (matrix_valid || r_pend) begin
                    r_mat  <= matrix_valid ? view_matrix : r_pend_mat;
                    r_pend <= 1'b0;
                end else if (in_valid && in_ready) begin
                    r_x     <= x_in;
                    r_y     <= y_in;
                    r_z     <= z_in;
                    r_tag   <= tag_in;
                    r_row   <= '0;
                    r_state <= S_ROW;
                end
            end else if (matrix_valid) begin
                r_pend_mat <= view_matrix;
                r_pend     <= 1'b1;
            end
            if (r_state == S_ROW) begin
                r_res[r_row] <= w_dot;
                r_row        <= r_row + 2'd1;
                if (r_row == 2'd3)
                    r_state <= S_OUT;
            end
            if (r_state == S_OUT && out_ready)
                r_state <= S_IDLE;
        end
    end
endmodule

// File: tb/tb_view_vertex_transformer.sv
// tb_view_vertex_transformer: directed vectors with a queue scoreboard and an independent output monitor
module tb_view_vertex_transformer;
    import view_vertex_transformer_pkg::*;
    logic        clk_in = 0;
    logic        rst_in = 0;
    logic        matrix_valid = 0;
    mat4_t       view_matrix = MAT_IDENTITY;
    logic        in_valid = 0;
    logic        in_ready;
    coord_t      x_in = 0, y_in = 0, z_in = 0;
    logic [7:0]  tag_in = 0;
    logic        out_valid;
    logic        out_ready = 1;
    coord_t      x_out, y_out, z_out, w_out;
    logic [7:0]  tag_out;
    int checks = 0, errors = 0, cyc = 0, out_hs_cyc = 0, last_hs = 0;
    bit seen = 0;
    typedef struct {coord_t x; coord_t y; coord_t z; coord_t w; logic [7:0] tag; int hs;} exp_t;
    exp_t q[$];
    localparam coord_t ONE = 32'h0001_0000;
    localparam coord_t TWO = 32'h0002_0000;
    localparam coord_t THR = 32'h0003_0000;
    view_vertex_transformer dut (
        .clk_in(clk_in), .rst_in(rst_in), .matrix_valid(matrix_valid), .view_matrix(view_matrix),
        .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .y_in(y_in), .z_in(z_in), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready), .x_out(x_out), .y_out(y_out), .z_out(z_out),
        .w_out(w_out), .tag_out(tag_out)
    );
    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc++;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    // Monitor: compares every cycle the output is presented (so held outputs must stay stable).
    always @(negedge clk_in) begin
        if (!out_valid) seen = 0;
        else if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got tag %h with out_valid, expected no output", tag_out);
        end else begin
            exp_t e;
            e = q[0];
            if (!seen) begin
                seen = 1;
                chk("latency", 64'(cyc - e.hs), 64'd5);
            end
            chk("x_out", x_out, e.x);
            chk("y_out", y_out, e.y);
            chk("z_out", z_out, e.z);
            chk("w_out", w_out, e.w);
            chk("tag_out", tag_out, e.tag);
            if (out_ready) begin
                void'(q.pop_front());
                out_hs_cyc = cyc;
                seen = 0;
            end
        end
    end
    task automatic send(input coord_t x, y, z, input logic [7:0] tag,
                        input coord_t ex, ey, ez, ew, input bit push);
        bit got = 0;
        exp_t e;
        x_in = x; y_in = y; z_in = z; tag_in = tag; in_valid = 1;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk_in);
            if (in_ready) begin
                got = 1;
                last_hs = cyc;
                e.x = ex; e.y = ey; e.z = ez; e.w = ew; e.tag = tag; e.hs = cyc;
                if (push) q.push_back(e);
            end
            @(posedge clk_in); #1;
        end
        in_valid = 0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: tag %h got no in_ready, expected acceptance", tag);
        end
    endtask
    task automatic load(input mat4_t m);
        view_matrix = m;
        matrix_valid = 1;
        @(posedge clk_in); #1;
        matrix_valid = 0;
    endtask
    task automatic drain();
        for (int k = 0; k < 100 && (q.size() != 0 || out_valid); k++) begin
            @(posedge clk_in); #1;
        end
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end
    initial begin
        mat4_t m, scale, junk;
        #3;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_x_out", x_out, 0);
        chk("rst_w_out", w_out, 0);
        chk("rst_tag_out", tag_out, 0);
        #19 rst_in = 1;
        #1 chk("in_ready_before_first_clk", in_ready, 0);
        @(posedge clk_in); #1;
        chk("in_ready_after_first_clk", in_ready, 1);
        // identity after reset
        send(ONE, TWO, THR, 8'h5A, ONE, TWO, THR, ONE, 1);
        drain();
        // translation
        m = MAT_IDENTITY; m[0][3] = 32'h0005_0000; m[2][3] = 32'hFFFE_0000;
        load(m);
        send(ONE, TWO, THR, 8'h21, 32'h0006_0000, TWO, ONE, ONE, 1);
        drain();
        // 90-degree z rotation
        m = MAT_IDENTITY; m[0][0] = 0; m[0][1] = 32'hFFFF_0000; m[1][0] = ONE; m[1][1] = 0;
        load(m);
        send(ONE, 0, 0, 8'h33, 0, ONE, 0, ONE, 1);
        drain();
        // backpressure: second vertex waits for the output handshake
        out_ready = 0;
        send(ONE, 0, 0, 8'h41, 0, ONE, 0, ONE, 1);
        fork
            send(0, ONE, 0, 8'h42, 32'hFFFF_0000, 0, 0, ONE, 1);
            begin
                for (int k = 0; k < 15; k++) begin
                    @(negedge clk_in);
                    chk("bp_in_ready", in_ready, 0);
                end
                @(posedge clk_in); #1;
                out_ready = 1;
            end
        join
        chk("bp_accept_after_out", 64'(last_hs), 64'(out_hs_cyc + 1));
        drain();
        // saturation both directions
        m = MAT_IDENTITY; m[0][0] = 32'h7FFF_0000;
        load(m);
        send(32'h0004_0000, 0, 0, 8'h51, 32'h7FFF_FFFF, 0, 0, ONE, 1);
        send(32'hFFFC_0000, 0, 0, 8'h52, 32'h8000_0000, 0, 0, ONE, 1);
        drain();
        // matrix pulses while busy: old matrix for in-flight vertex, last pulse wins
        load(MAT_IDENTITY);
        scale = MAT_IDENTITY; scale[0][0] = TWO; scale[1][1] = TWO; scale[2][2] = TWO;
        junk = '{default: THR};
        send(ONE, TWO, THR, 8'h61, ONE, TWO, THR, ONE, 1);
        load(junk);
        load(scale);
        send(ONE, ONE, ONE, 8'h62, TWO, TWO, TWO, ONE, 1);
        drain();
        // async reset while the result is held
        out_ready = 0;
        send(ONE, 0, 0, 8'h71, TWO, 0, 0, ONE, 1);
        for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk_in);
        chk("out_valid_before_reset", out_valid, 1);
        #2 rst_in = 0;
        #1 chk("rst_out_drops_async", out_valid, 0);
        q.delete();
        out_ready = 1;
        @(negedge clk_in); #2 rst_in = 1;
        @(posedge clk_in); #1;
        // async reset mid-ROW with a pending matrix: both are discarded
        send(ONE, TWO, THR, 8'h81, 0, 0, 0, 0, 0);
        load(scale);
        #2 rst_in = 0;
        #1 chk("rst_row_out_valid", out_valid, 0);
        chk("rst_row_in_ready", in_ready, 0);
        chk("rst_row_x_out", x_out, 0);
        repeat (2) @(negedge clk_in);
        #2 rst_in = 1;
        @(posedge clk_in); #1;
        send(ONE, TWO, THR, 8'h82, ONE, TWO, THR, ONE, 1);
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
